// File: rtl/cnt_disp_pkg.sv
// Shared types and constants for the BCD display slice: converter FSM states
// and the 7-segment glyph table.
package cnt_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] BLANK = 7'h00;

  // Segments {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    if (nib <= 4'd9) begin
      seg = SEG_TABLE[nib];
    end else begin
      seg = BLANK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep pending
// request slot; the result register only changes on commit.
module bin2bcd_seq
  import cnt_disp_pkg::*;
#(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 5
) (
  input  logic                  clk25,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      value_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] MAX_IN = (64'd1 << BIN_W) - 64'd1;

  generate
    if (MAX_IN >= pow10(DIGITS)) begin : g_width_check
      $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end
  endgenerate

  state_t             state, state_n;
  logic [BIN_W-1:0]   bin_sr, bin_n;
  logic [BCD_W-1:0]   bcd_acc, bcd_n, adj;
  logic [CNT_W-1:0]   bit_cnt, cnt_n;
  logic               pend, pend_n;
  logic [BIN_W-1:0]   pend_val, pval_n;
  logic [BCD_W-1:0]   disp_n;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    adj = bcd_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd_acc[4*i +: 4];
      end
    end
  end

  // Next-state, datapath and pending-slot logic.
  always_comb begin
    state_n = state;
    bin_n   = bin_sr;
    bcd_n   = bcd_acc;
    cnt_n   = bit_cnt;
    pend_n  = pend;
    pval_n  = pend_val;
    disp_n  = bcd_out;
    case (state)
      IDLE: begin
        if (load) begin
          bin_n   = value_in;
          bcd_n   = '0;
          cnt_n   = CNT_W'(BIN_W);
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        {bcd_n, bin_n} = {adj[BCD_W-2:0], bin_sr, 1'b0};
        cnt_n = bit_cnt - CNT_W'(1);
        if (bit_cnt == CNT_W'(1)) begin
          state_n = COMMIT;
        end else begin
          state_n = SHIFT;
        end
        if (load) begin
          pend_n = 1'b1;
          pval_n = value_in;
        end else begin
          pend_n = pend;
        end
      end
      COMMIT: begin
        disp_n = bcd_acc;
        if (pend) begin
          // The queued request starts now; a load this cycle refills the slot.
          bin_n   = pend_val;
          bcd_n   = '0;
          cnt_n   = CNT_W'(BIN_W);
          state_n = SHIFT;
          pend_n  = load;
          if (load) begin
            pval_n = value_in;
          end else begin
            pval_n = pend_val;
          end
        end else if (load) begin
          bin_n   = value_in;
          bcd_n   = '0;
          cnt_n   = CNT_W'(BIN_W);
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        pend_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_acc  <= '0;
      bit_cnt  <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      bcd_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bin_sr   <= bin_n;
      bcd_acc  <= bcd_n;
      bit_cnt  <= cnt_n;
      pend     <= pend_n;
      pend_val <= pval_n;
      bcd_out  <= disp_n;
      busy     <= (state_n != IDLE);
      done     <= (state_n == COMMIT);
    end
  end

endmodule

// File: rtl/cnt_bcd_display.sv
// Binary count to time-multiplexed 7-segment display: BCD conversion plus
// digit scanner, leading-zero blanking and segment decode.
module cnt_bcd_display
  import cnt_disp_pkg::*;
#(
  parameter int BIN_W         = 15,
  parameter int DIGITS        = 5,
  parameter int SCAN_LOG2     = 10,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value_in,
  input  logic             load,
  output logic [6:0]       seg_out,
  output logic             dp_out,
  output logic [2:0]       digit_sel,
  output logic             busy,
  output logic             done
);

  logic [4*DIGITS-1:0]  bcd;
  logic [SCAN_LOG2-1:0] prescaler;
  logic [3:0]           nib;
  logic                 blank;
  logic                 zero_above;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk25    (clk25),
    .rst_n    (rst_n),
    .value_in (value_in),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd)
  );

  // Free-running prescaler; digit advances on each wrap.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit_sel <= 3'd0;
    end else begin
      prescaler <= prescaler + SCAN_LOG2'(1);
      if (prescaler == {SCAN_LOG2{1'b1}}) begin
        if (digit_sel == 3'(DIGITS - 1)) begin
          digit_sel <= 3'd0;
        end else begin
          digit_sel <= digit_sel + 3'd1;
        end
      end else begin
        digit_sel <= digit_sel;
      end
    end
  end

  // Digit select, leading-zero detection (scanning from the top digit down).
  always_comb begin
    nib        = 4'd0;
    blank      = 1'b0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
      if (digit_sel == 3'(i)) begin
        nib   = bcd[4*i +: 4];
        blank = (BLANK_LEADING != 0) && (i > 0) && zero_above;
      end else begin
        nib   = nib;
      end
    end
  end

  assign seg_out = blank ? BLANK : seg_decode(nib);
  assign dp_out  = busy;

endmodule

// File: tb/tb_cnt_bcd_display.sv
// Directed + randomized bench for cnt_bcd_display against a decimal-arithmetic
// display model.
module tb_cnt_bcd_display;

  localparam int SCAN = 5;
  localparam int DWELL = 1 << SCAN;

  logic        clk25 = 1'b0;
  logic        rst_n;
  logic [14:0] value_in;
  logic        load;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [2:0]  digit_sel;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  cnt_bcd_display #(
    .BIN_W         (15),
    .DIGITS        (5),
    .SCAN_LOG2     (SCAN),
    .BLANK_LEADING (1)
  ) dut (
    .clk25     (clk25),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .load      (load),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .digit_sel (digit_sel),
    .busy      (busy),
    .done      (done)
  );

  always #20 clk25 = ~clk25;

  task automatic tick;
    @(posedge clk25);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Expected glyph for decimal position d of value v, with leading-zero blanking.
  function automatic logic [6:0] exp_seg(input int v, input int d);
    if (d > 0 && v < pow10(d)) return 7'h00;
    return glyph[(v / pow10(d)) % 10];
  endfunction

  task automatic show_check(input string tag, input int v);
    for (int d = 0; d < 5; d++) begin
      int t = 0;
      while (digit_sel !== 3'(d) && t < 8 * DWELL) begin
        tick();
        t++;
      end
      check({tag, "_sel"}, 32'(digit_sel), 32'(d));
      check($sformatf("%s_seg%0d", tag, d), 32'(seg_out), 32'(exp_seg(v, d)));
    end
    check({tag, "_dp"}, 32'(dp_out), 32'd0);
  endtask

  task automatic run_load(input string tag, input int v);
    int lat = -1;
    value_in = 15'(v);
    load = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        load = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd16);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    show_check(tag, v);
  endtask

  initial begin
    int t;
    int d1, d2, drops, seen;
    rst_n = 1'b0;
    load = 1'b0;
    value_in = 15'd0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_seg0", 32'(seg_out), 32'h3F);
    rst_n = 1'b1;
    t = 0;
    while (digit_sel !== 3'd1 && t < 4 * DWELL) begin
      tick();
      t++;
    end
    check("dwell", 32'(t), 32'(DWELL));
    show_check("rst_scan", 0);

    run_load("v12345", 12345);
    run_load("vmax", 32767);

    // Reset in the middle of a conversion of 999.
    value_in = 15'd999;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    show_check("midrst", 0);

    run_load("v1007", 1007);
    run_load("v0", 0);

    // Back-to-back requests: 200 is superseded by 300 while 100 converts.
    d1 = -1;
    d2 = -1;
    drops = 0;
    for (int c = 1; c <= 40; c++) begin
      case (c)
        1: begin value_in = 15'd100; load = 1'b1; end
        2: load = 1'b0;
        4: begin value_in = 15'd200; load = 1'b1; end
        5: load = 1'b0;
        9: begin value_in = 15'd300; load = 1'b1; end
        10: load = 1'b0;
        default: ;
      endcase
      tick();
      if (d2 < 0 && busy !== 1'b1) drops++;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    check("pend_done1", 32'(d1), 32'd16);
    check("pend_done2", 32'(d2), 32'd32);
    check("pend_busy_hold", 32'(drops), 32'd0);
    show_check("pend", 300);

    for (int r = 0; r < 6; r++) begin
      run_load($sformatf("rnd%0d", r), int'($urandom_range(32767, 0)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
